lsu_data: RTL and testbench

- Load/store unit sitting directly upstream of the RV32I data memory.
- Accepts one load/store request at a time from the execute stage and drives the memory's word-only read/write enables.
- Performs byte/halfword lane extraction with sign/zero extension on loads.
- Performs read-modify-write for SB/SH, since the memory has no byte enables.
- Flags misaligned accesses and illegal funct3 values without touching memory.

---
 rtl/trv_lsu_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu_data.sv | 143 ++++++++++++++
 tb/tb_lsu_data.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit.
//   - F3_* : RV32I funct3 encodings for loads/stores
//   - lsu_state_t : FSM state encoding (also exported on the debug port)
//   - is_misaligned / is_illegal : request decode helpers used in IDLE
package trv_lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4,
    ERR  = 3'd5
  } lsu_state_t;

  // Access size lives in funct3[1:0]; byte accesses are never misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr);
    case (funct3[1:0])
      2'b01:   return addr[0];
      2'b10:   return addr != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic       we,
                                      input logic [2:0] funct3);
    if (we) return funct3[2] || (funct3 == 3'b011);
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction / merge for the load/store unit (purely combinational).
//   word         : memory word the access operates on
//   addr         : byte offset within the word
//   funct3       : RV32I funct3 of the access
//   store_data   : store operand (low byte/halfword used for SB/SH)
//   load_ext     : selected lane, sign- or zero-extended
//   store_merged : word with the selected lane replaced by store_data
module lsu_align
  import trv_lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_ext,
  output logic [XLEN-1:0] store_merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word[{addr, 3'b000} +: 8];
  assign half_lane = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_ext = '0;
    case (funct3)
      F3_B:    load_ext = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_ext = {{16{half_lane[15]}}, half_lane};
      F3_W:    load_ext = word;
      F3_BU:   load_ext = {24'h0, byte_lane};
      F3_HU:   load_ext = {16'h0, half_lane};
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    store_merged = word;
    case (funct3[1:0])
      2'b00: store_merged[{addr, 3'b000} +: 8] = store_data[7:0];
      2'b01: begin
        if (addr[1]) store_merged[31:16] = store_data[15:0];
        else         store_merged[15:0]  = store_data[15:0];
      end
      default: store_merged = store_data;
    endcase
  end

endmodule

// File: rtl/lsu_data.sv
// RV32I load/store unit in front of a word-only data memory.
// One request at a time; sub-word stores use read-modify-write.
//   clk, rst            : clock, async active-low reset
//   req_*               : request from execute. Handshake: a request is taken
//                         on a rising edge where req_valid && req_ready; the
//                         request inputs are ignored in every other cycle.
//   resp_valid/rdata/err: one-cycle completion pulse, no backpressure
//   mem_*               : word address, read/write enables, write/read data
//   dbg_state           : current FSM state
// Memory protocol: read_en is held two cycles; the memory registers its
// fetch on the first edge, so mem_rdata is sampled in the second cycle.
module lsu_data
  import trv_lsu_pkg::*;
#(
  parameter int B_WIDTH   = 32,
  parameter bit WORD_ADDR = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [B_WIDTH-1:0] req_addr,
  input  logic [B_WIDTH-1:0] req_wdata,
  output logic               resp_valid,
  output logic [B_WIDTH-1:0] resp_rdata,
  output logic               resp_err,
  output logic [B_WIDTH-1:0] mem_addr,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic [B_WIDTH-1:0] mem_wdata,
  input  logic [B_WIDTH-1:0] mem_rdata,
  output lsu_state_t         dbg_state
);

  if (B_WIDTH != 32) begin : g_bad_width
    $fatal(1, "lsu_data: only B_WIDTH=32 is supported");
  end

  lsu_state_t         state;
  logic [1:0]         addr_lo_q;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [B_WIDTH-1:0] wdata_q;
  logic [B_WIDTH-1:0] word_q;

  logic [B_WIDTH-1:0] req_word_addr;
  logic               req_err;
  logic [B_WIDTH-1:0] align_word;
  logic [B_WIDTH-1:0] load_ext;
  logic [B_WIDTH-1:0] store_merged;

  assign req_word_addr = WORD_ADDR ? {2'b00, req_addr[B_WIDTH-1:2]}
                                   : {req_addr[B_WIDTH-1:2], 2'b00};
  assign req_err   = is_illegal(req_we, req_funct3) ||
                     is_misaligned(req_funct3, req_addr[1:0]);
  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  // In RD2 the bus word is not yet in word_q; align straight from the bus so
  // the response / merged store word can be registered on the same edge.
  assign align_word = (state == RD2) ? mem_rdata : word_q;

  lsu_align u_align (
    .word         (align_word),
    .addr         (addr_lo_q),
    .funct3       (f3_q),
    .store_data   (wdata_q),
    .load_ext     (load_ext),
    .store_merged (store_merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr_lo_q    <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      mem_addr     <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_lo_q <= req_addr[1:0];
            we_q      <= req_we;
            f3_q      <= req_funct3;
            wdata_q   <= req_wdata;
            mem_addr  <= req_word_addr;
            if (req_err) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && (req_funct3 == F3_W)) begin
              state        <= WR;
              mem_write_en <= 1'b1;
              mem_wdata    <= req_wdata;
            end else begin
              // Loads, and SB/SH which must first fetch the word to merge.
              state       <= RD1;
              mem_read_en <= 1'b1;
            end
          end
        end
        RD1: state <= RD2;
        RD2: begin
          word_q      <= mem_rdata;
          mem_read_en <= 1'b0;
          if (!we_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_ext;
          end else begin
            state        <= WR;
            mem_write_en <= 1'b1;
            mem_wdata    <= store_merged;
          end
        end
        WR: begin
          mem_write_en <= 1'b0;
          state        <= RESP;
          resp_valid   <= 1'b1;
        end
        RESP, ERR: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_data.sv
module tb_lsu_data;
  import trv_lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  lsu_state_t  dbg_state;

  lsu_data #(.B_WIDTH(32), .WORD_ADDR(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // ---------------- memory stub (registered fetch) ----------------
  logic [31:0] mem_arr [0:63];
  logic [31:0] rd_q = 32'd0;
  always @(posedge clk) begin
    if (mem_write_en) mem_arr[mem_addr[5:0]] <= mem_wdata;
    if (mem_read_en)  rd_q <= mem_arr[mem_addr[5:0]];
  end
  assign mem_rdata = mem_read_en ? rd_q : 32'h0;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_q[$];

  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic [31:0] wd,
                                output bit err, output int lat,
                                output int rdc, output int wrc);
    int idx, sh, nbytes;
    bit legal;
    logic [63:0] mask64;
    logic [31:0] mask, v;
    idx    = int'(addr[7:2]);
    sh     = int'(addr[1:0]) * 8;
    legal  = we ? (f3 inside {3'd0, 3'd1, 3'd2})
                : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nbytes = 1 << f3[1:0];
    err    = !legal || ((int'(addr[1:0]) % nbytes) != 0);
    mask64 = (64'd1 << (8 * nbytes)) - 64'd1;
    mask   = mask64[31:0];
    rd = 32'd0; wd = 32'd0; lat = 1; rdc = 0; wrc = 0;
    if (err) return;
    if (!we) begin
      lat = 3; rdc = 2;
      v = (ref_mem[idx] >> sh) & mask;
      if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      rd = v;
    end else begin
      wrc = 1;
      if (nbytes == 4) begin
        lat = 2;
        ref_mem[idx] = wdata;
      end else begin
        lat = 4; rdc = 2;
        ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
      end
      wd = ref_mem[idx];
    end
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) check_eq("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output logic [31:0] got);
    logic [31:0] exp_rd, exp_wd, exp_ma, addr_seen, wd_seen;
    bit exp_err, both_en, done;
    int exp_lat, exp_rdc, exp_wrc, lat, rdc, wrc;
    model(we, f3, addr, wdata, exp_rd, exp_wd, exp_err, exp_lat, exp_rdc, exp_wrc);
    exp_q.push_back(exp_rd);
    exp_ma = {2'b00, addr[31:2]};
    addr_seen = exp_ma; wd_seen = 32'd0;
    both_en = 1'b0; done = 1'b0; lat = 0; rdc = 0; wrc = 0; got = 32'd0;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (!hold && lat == 1) req_valid = 1'b0;
      if (mem_read_en && mem_write_en) both_en = 1'b1;
      if (mem_read_en) rdc++;
      if (mem_write_en) begin
        wrc++;
        wd_seen = mem_wdata;
      end
      if ((mem_read_en || mem_write_en) && mem_addr !== exp_ma) addr_seen = mem_addr;
      if (resp_valid) begin
        done = 1'b1;
        got  = resp_rdata;
        check_eq("resp_err", 32'(resp_err), 32'(exp_err));
        check_eq("resp_rdata", resp_rdata, exp_q.pop_front());
      end
    end
    if (!done) begin
      check_eq("resp_timeout", 32'(done), 32'd1);
      void'(exp_q.pop_front());
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("both_en", 32'(both_en), 32'd0);
    check_eq("rd_cycles", 32'(rdc), 32'(exp_rdc));
    check_eq("wr_cycles", 32'(wrc), 32'(exp_wrc));
    if (rdc + wrc > 0) check_eq("mem_addr", addr_seen, exp_ma);
    if (exp_wrc > 0) check_eq("mem_wdata", wd_seen, exp_wd);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] got, saved;
    logic        any_resp;

    // reset values (async)
    #1;
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_rd_en", 32'(mem_read_en), 32'd0);
    check_eq("rst_wr_en", 32'(mem_write_en), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(req_ready), 32'd1);

    // preload every word through the unit with SW
    for (int i = 0; i < 64; i++) do_req(1'b1, F3_W, 32'(i * 4), $urandom, 1'b0, got);

    // SW then LW at 0x10
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, got);
    do_req(1'b0, F3_W, 32'h10, 32'h0, 1'b0, got);
    check_eq("lw_deadbeef", got, 32'hDEADBEEF);

    // sub-word loads from 0x8000FF80
    do_req(1'b1, F3_W, 32'h20, 32'h8000FF80, 1'b0, got);
    do_req(1'b0, F3_B, 32'h20, 32'h0, 1'b0, got);
    check_eq("lb_20", got, 32'hFFFFFF80);
    do_req(1'b0, F3_BU, 32'h20, 32'h0, 1'b0, got);
    check_eq("lbu_20", got, 32'h00000080);
    do_req(1'b0, F3_H, 32'h22, 32'h0, 1'b0, got);
    check_eq("lh_22", got, 32'hFFFF8000);
    do_req(1'b0, F3_HU, 32'h22, 32'h0, 1'b0, got);
    check_eq("lhu_22", got, 32'h00008000);

    // SB read-modify-write
    do_req(1'b1, F3_W, 32'h20, 32'h11223344, 1'b0, got);
    do_req(1'b1, F3_B, 32'h21, 32'h000000AB, 1'b0, got);
    do_req(1'b0, F3_W, 32'h20, 32'h0, 1'b0, got);
    check_eq("sb_merge", got, 32'h1122AB44);

    // errors: misaligned LW / SH, illegal load funct3
    do_req(1'b0, F3_W, 32'h12, 32'h0, 1'b0, got);
    do_req(1'b1, F3_H, 32'h13, 32'h5555, 1'b0, got);
    do_req(1'b0, 3'b011, 32'h30, 32'h0, 1'b0, got);

    // req_valid held high while busy: one acceptance per response
    do_req(1'b0, F3_W, 32'h20, 32'h0, 1'b1, got);
    do_req(1'b0, F3_W, 32'h20, 32'h0, 1'b1, got);
    req_valid = 1'b0;
    any_resp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) any_resp = 1'b1;
    end
    check_eq("no_extra_accept", 32'(any_resp), 32'd0);

    // reset in RD2 of an SB
    saved = ref_mem[8];
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
    req_addr = 32'h21; req_wdata = 32'h000000CD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rmw_rd1_en", 32'(mem_read_en), 32'd1);
    @(negedge clk);
    check_eq("rmw_rd2_en", 32'(mem_read_en), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("abort_rd_en", 32'(mem_read_en), 32'd0);
    check_eq("abort_wr_en", 32'(mem_write_en), 32'd0);
    any_resp = resp_valid;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || mem_write_en) any_resp = 1'b1;
    end
    check_eq("abort_no_resp", 32'(any_resp), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", 32'(req_ready), 32'd1);
    check_eq("abort_state", 32'(dbg_state), 32'(IDLE));
    check_eq("abort_mem_word", mem_arr[8], saved);
    do_req(1'b0, F3_W, 32'h20, 32'h0, 1'b0, got);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 255)), $urandom, 1'b0, got);
    end

    // final sweep: DUT-side memory must match the reference image
    for (int i = 0; i < 64; i++) check_eq("final_mem", mem_arr[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
